data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter that shares the single data bus (memory at 0x0xxx, on-chip FP multiplier at 0x1xxx, board I/O at 0x2xxx) between the pipeline memory stage (master 0) and a secondary requester such as the DMA/IR engine (master 1). It sits between the masters and the bus port. It serializes transactions with round-robin priority and holds a grant until the bus signals completion. It also forces one idle bus cycle between transactions so toggle-style done flags return low.

## Interface
- TIMEOUT_CYCLES, 255: cycles a grant may stay open without done before it is aborted (used only with ARB_TIMEOUT_EN); range 1..255.
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- m0_read, m0_write  in  1 each  master 0 request strobes; mutually exclusive, held until m0_done.
- m0_addr, m0_wdata  in  16 each  master 0 address / write data, stable while requesting.
- m0_rdata  out  16  read data to master 0, valid when m0_done=1.
- m0_done  out  1  one-cycle completion pulse to master 0.
- m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_done  same as master 0, for master 1.
- s_read, s_write  out  1 each  strobes to the bus (ReadData/WriteData).
- s_addr, s_wdata  out  16 each  to bus DataAddr / BusIn.
- s_rdata  in  16  from bus BusOut.
- s_done  in  1  from bus DataDone.
- err_timeout  out  1  sticky timeout flag, cleared only by Reset.

## Operation
- States: ARB_IDLE, ARB_GRANT0, ARB_GRANT1. Reset → ARB_IDLE, priority pointer = master 0.
- ARB_IDLE: slave strobes 0, s_addr/s_wdata 0, all done 0. A master requests when read|write=1. One requester → grant it. Both → grant the pointer master. None → stay.
- ARB_GRANTn: s_read/s_write/s_addr/s_wdata pass through combinationally from master n. m(n)_rdata = s_rdata; the other master's rdata = 0.
- s_done is honoured only in a GRANT state with master n still requesting. Unsolicited s_done in IDLE is ignored, since I/O reports done constantly.
- On an honoured s_done: m(n)_done=1 that cycle. Next state is ARB_IDLE. Pointer moves to the other master.
- A master dropping its request before done abandons the grant: return to ARB_IDLE, pointer unchanged, no done pulse.
- The non-granted master sees done=0 and rdata=0 and must keep its request asserted.
- Reset mid-transaction abandons it. Outputs drop to reset values immediately.

## Timing
- Reset values: all outputs 0.
- Request in IDLE at cycle t → grant registered at edge t+1 → bus strobes visible during cycle t+1.
- Memory: done in cycle t+2 → total latency 2. I/O: done in cycle t+1 → latency 1.
- After done in cycle d, state is IDLE in d+1. The next grant is earliest at d+2 for any master. Throughput is at most one transaction per 2 cycles.
- No combinational path from s_done to s_read/s_write. A path from s_done to m*_done is allowed.

## Configuration
- ARB_TIMEOUT_EN defined: an 8-bit watchdog counts cycles in a GRANT state and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES without an honoured done: m(n)_done=1 and m(n)_rdata=16'hDEAD for one cycle, err_timeout set, next state IDLE, pointer advances.
  - A real s_done on the same cycle wins; no error is raised.
- ARB_TIMEOUT_EN undefined: a grant is held indefinitely, err_timeout is tied 0, and no counter is synthesized.

## Structure
- Package bus_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1};
  - localparam ARB_TIMEOUT_RDATA = 16'hDEAD;
  - localparam ARB_WD_WIDTH = 8.
- One sub-module, bus_arb_watchdog (counter plus expiry compare), is instantiated only under ARB_TIMEOUT_EN.
- The grant FSM, pointer and muxes stay in data_bus_arbiter.

## Test plan
- Single memory read: m0_read at addr 0x0010, s_rdata=0x1234, s_done high on the 2nd granted cycle → m0_done pulses at t+2 with m0_rdata=0x1234. The bus is idle at t+3.
- Simultaneous requests after reset: m0_write 0x2200 data 0x03FF, m1_read 0x2100 → m0 granted first (ledr write). m1 is granted 2 cycles after m0_done. Pointer then returns to m0.
- Back-to-back contention, both masters continuously requesting 4 transactions each → grants strictly alternate m0,m1,m0,… with exactly one IDLE cycle between.
- s_done=1 while IDLE with no requests → no done pulse and no state change.
- Reset asserted mid-grant to m1 → s_read, m1_done and err_timeout are 0 immediately. The first post-reset contention grants m0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, s_done held 0 → m0_done pulses on the 4th granted cycle with rdata 0xDEAD. err_timeout stays 1 until Reset.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
// Imported by data_bus_arbiter and bus_arb_watchdog.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [15:0] ARB_TIMEOUT_RDATA = 16'hDEAD;
    localparam int          ARB_WD_WIDTH      = 8;

endpackage

// File: rtl/bus_arb_watchdog.sv
// Grant watchdog: counts cycles spent in a grant state and flags expiry.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module bus_arb_watchdog
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic active_i,
    output logic expired_o
);

    localparam logic [ARB_WD_WIDTH-1:0] LAST =
        ARB_WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [ARB_WD_WIDTH-1:0] cnt_q, cnt_d;

    // Count while a grant is open, restart from zero whenever idle.
    always_comb begin
        cnt_d = '0;
        if (active_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = active_i && (cnt_q == LAST);

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin two-master arbiter for the shared data bus.
// Optional grant watchdog enabled with `define ARB_TIMEOUT_EN.
module data_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_done,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_done,
    output logic        s_read,
    output logic        s_write,
    output logic [15:0] s_addr,
    output logic [15:0] s_wdata,
    input  logic [15:0] s_rdata,
    input  logic        s_done,
    output logic        err_timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    arb_state_t  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        req0, req1;
    logic        sel1, granted, own_req;
    logic        wd_expired, tmo_fire;
    logic        own_done;
    logic [15:0] own_rdata;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign sel1    = (state_q == ARB_GRANT1);
    assign granted = (state_q != ARB_IDLE);
    assign own_req = sel1 ? req1 : req0;

    // A real done always beats an expiring watchdog.
    assign tmo_fire = granted && own_req && !s_done && wd_expired;

`ifdef ARB_TIMEOUT_EN
    logic err_q;

    bus_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .Clock    (Clock),
        .Reset    (Reset),
        .active_i (granted),
        .expired_o(wd_expired)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (tmo_fire) begin
            err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign wd_expired  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Grant FSM next state, pointer update and bus/master muxes.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        own_done  = 1'b0;
        own_rdata = s_rdata;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    state_d = ptr_q ? ARB_GRANT1 : ARB_GRANT0;
                end else if (req0) begin
                    state_d = ARB_GRANT0;
                end else if (req1) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                s_read  = sel1 ? m1_read  : m0_read;
                s_write = sel1 ? m1_write : m0_write;
                s_addr  = sel1 ? m1_addr  : m0_addr;
                s_wdata = sel1 ? m1_wdata : m0_wdata;
                if (!own_req) begin
                    // Abandoned grant keeps the pointer where it was.
                    state_d = ARB_IDLE;
                end else if (s_done) begin
                    own_done = 1'b1;
                    state_d  = ARB_IDLE;
                    ptr_d    = !sel1;
                end else if (tmo_fire) begin
                    own_done  = 1'b1;
                    own_rdata = ARB_TIMEOUT_RDATA;
                    state_d   = ARB_IDLE;
                    ptr_d     = !sel1;
                end
                if (sel1) begin
                    m1_done  = own_done;
                    m1_rdata = own_rdata;
                end else begin
                    m0_done  = own_done;
                    m0_rdata = own_rdata;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and round-robin pointer registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_data_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        Clock, Reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done;
    logic        s_read, s_write, s_done, err_timeout;
    logic [15:0] s_addr, s_wdata, s_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    data_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .s_read(s_read), .s_write(s_write),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_done(s_done),
        .err_timeout(err_timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        m0r, m0w;
        logic [15:0] m0a, m0d;
        logic        m1r, m1w;
        logic [15:0] m1a, m1d;
        logic [15:0] srd;
        logic        sd;
        logic [68:0] exp;
    } vec_t;

    vec_t vt[18];

    function automatic logic [68:0] eo(
        logic sr, logic sw, logic [15:0] sa, logic [15:0] swd,
        logic d0, logic [15:0] r0, logic d1, logic [15:0] r1,
        logic err);
        return {sr, sw, sa, swd, d0, r0, d1, r1, err};
    endfunction

    function automatic logic [68:0] outs();
        return {s_read, s_write, s_addr, s_wdata, m0_done, m0_rdata,
                m1_done, m1_rdata, err_timeout};
    endfunction

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(logic m0r, logic m0w, logic [15:0] m0a,
                         logic [15:0] m0d, logic m1r, logic m1w,
                         logic [15:0] m1a, logic [15:0] m1d,
                         logic [15:0] srd, logic sd);
        m0_read = m0r; m0_write = m0w; m0_addr = m0a; m0_wdata = m0d;
        m1_read = m1r; m1_write = m1w; m1_addr = m1a; m1_wdata = m1d;
        s_rdata = srd; s_done = sd;
    endtask

    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
              16'h0, 1'b0);
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    function automatic logic [15:0] fmem(logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Random-run model state
    int          owner, ptr_m, lat, cnt;
    bit          act[2];
    logic        rd[2];
    logic [15:0] ad[2], wd[2];
    int          k[2];
    logic [68:0] e;

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
              16'h0, 1'b0);
        @(negedge Clock);
        chk("reset_outs", outs(), 69'h0);

        // inputs                                            srd      sd
        vt[0]  = '{1'b0,1'b0,16'h0,16'h0,1'b0,1'b0,16'h0,16'h0,16'hFFFF,1'b1,
                   69'h0};
        vt[1]  = '{1'b0,1'b1,16'h2200,16'h03FF,1'b1,1'b0,16'h2100,16'h0,
                   16'h0,1'b0,69'h0};
        vt[2]  = '{1'b0,1'b1,16'h2200,16'h03FF,1'b1,1'b0,16'h2100,16'h0,
                   16'h5555,1'b1,
                   eo(1'b0,1'b1,16'h2200,16'h03FF,1'b1,16'h5555,
                      1'b0,16'h0,1'b0)};
        vt[3]  = '{1'b0,1'b0,16'h0,16'h0,1'b1,1'b0,16'h2100,16'h0,
                   16'h5555,1'b0,69'h0};
        vt[4]  = '{1'b0,1'b0,16'h0,16'h0,1'b1,1'b0,16'h2100,16'h0,
                   16'h00AB,1'b1,
                   eo(1'b1,1'b0,16'h2100,16'h0,1'b0,16'h0,
                      1'b1,16'h00AB,1'b0)};
        vt[5]  = '{1'b0,1'b0,16'h0,16'h0,1'b0,1'b0,16'h0,16'h0,
                   16'h0,1'b0,69'h0};
        vt[6]  = '{1'b1,1'b0,16'h0010,16'h0,1'b1,1'b0,16'h0020,16'h0,
                   16'h0,1'b0,69'h0};
        vt[7]  = '{1'b1,1'b0,16'h0010,16'h0,1'b1,1'b0,16'h0020,16'h0,
                   16'h1234,1'b0,
                   eo(1'b1,1'b0,16'h0010,16'h0,1'b0,16'h1234,
                      1'b0,16'h0,1'b0)};
        vt[8]  = '{1'b1,1'b0,16'h0010,16'h0,1'b1,1'b0,16'h0020,16'h0,
                   16'h1234,1'b1,
                   eo(1'b1,1'b0,16'h0010,16'h0,1'b1,16'h1234,
                      1'b0,16'h0,1'b0)};
        vt[9]  = '{1'b0,1'b0,16'h0,16'h0,1'b1,1'b0,16'h0020,16'h0,
                   16'h7777,1'b1,69'h0};
        vt[10] = '{1'b0,1'b0,16'h0,16'h0,1'b1,1'b0,16'h0020,16'h0,
                   16'h0,1'b0,
                   eo(1'b1,1'b0,16'h0020,16'h0,1'b0,16'h0,
                      1'b0,16'h0,1'b0)};
        vt[11] = '{1'b0,1'b0,16'h0,16'h0,1'b0,1'b0,16'h0,16'h0,
                   16'h0,1'b1,69'h0};
        vt[12] = '{1'b1,1'b0,16'h0030,16'h0,1'b1,1'b0,16'h0040,16'h0,
                   16'h0,1'b0,69'h0};
        vt[13] = '{1'b1,1'b0,16'h0030,16'h0,1'b1,1'b0,16'h0040,16'h0,
                   16'h0BEE,1'b0,
                   eo(1'b1,1'b0,16'h0040,16'h0,1'b0,16'h0,
                      1'b0,16'h0BEE,1'b0)};
        vt[14] = '{1'b1,1'b0,16'h0030,16'h0,1'b1,1'b0,16'h0040,16'h0,
                   16'h0BEE,1'b1,
                   eo(1'b1,1'b0,16'h0040,16'h0,1'b0,16'h0,
                      1'b1,16'h0BEE,1'b0)};
        vt[15] = '{1'b1,1'b0,16'h0030,16'h0,1'b0,1'b0,16'h0,16'h0,
                   16'h0,1'b0,69'h0};
        vt[16] = '{1'b1,1'b0,16'h0030,16'h0,1'b0,1'b0,16'h0,16'h0,
                   16'h4321,1'b1,
                   eo(1'b1,1'b0,16'h0030,16'h0,1'b1,16'h4321,
                      1'b0,16'h0,1'b0)};
        vt[17] = '{1'b0,1'b0,16'h0,16'h0,1'b0,1'b0,16'h0,16'h0,
                   16'h0,1'b0,69'h0};

        @(posedge Clock); #1;
        Reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(posedge Clock); #1;
            drive(vt[i].m0r, vt[i].m0w, vt[i].m0a, vt[i].m0d,
                  vt[i].m1r, vt[i].m1w, vt[i].m1a, vt[i].m1d,
                  vt[i].srd, vt[i].sd);
            @(negedge Clock);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // Reset asserted in the middle of a grant to master 1
        @(posedge Clock); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0,
              16'h0, 1'b0);
        @(posedge Clock); #1;
        s_done = 1'b1;
        #1;
        chk("pre_rst_m1done", {79'h0, m1_done}, 80'h1);
        Reset = 1'b1;
        #1;
        chk("rst_sread", {79'h0, s_read}, 80'h0);
        chk("rst_m1done", {79'h0, m1_done}, 80'h0);
        chk("rst_err", {79'h0, err_timeout}, 80'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Back-to-back contention: four reads each, I/O-style done
        k[0] = 0;
        k[1] = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                @(posedge Clock); #1;
            end
            drive(k[0] < 4, 1'b0, 16'h0100 + 16'(k[0]), 16'h0,
                  k[1] < 4, 1'b0, 16'h0200 + 16'(k[1]), 16'h0,
                  16'hC000 + 16'(c), 1'b1);
            @(negedge Clock);
            if (c % 2 == 0) begin
                e = 69'h0;
            end else if (((c - 1) / 2) % 2 == 0) begin
                e = eo(1'b1, 1'b0, 16'h0100 + 16'(k[0]), 16'h0,
                       1'b1, 16'hC000 + 16'(c), 1'b0, 16'h0, 1'b0);
                k[0]++;
            end else begin
                e = eo(1'b1, 1'b0, 16'h0200 + 16'(k[1]), 16'h0,
                       1'b0, 16'h0, 1'b1, 16'hC000 + 16'(c), 1'b0);
                k[1]++;
            end
            chk($sformatf("b2b%0d", c), outs(), e);
        end

`ifdef ARB_TIMEOUT_EN
        // Watchdog expiry with no done from the bus
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            drive(c < 5, 1'b0, 16'h2000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                  16'h0, 1'b0);
            @(negedge Clock);
            if (c == 0) e = 69'h0;
            else if (c < 4)
                e = eo(1'b1, 1'b0, 16'h2000, 16'h0, 1'b0, 16'h0,
                       1'b0, 16'h0, 1'b0);
            else if (c == 4)
                e = eo(1'b1, 1'b0, 16'h2000, 16'h0, 1'b1, 16'hDEAD,
                       1'b0, 16'h0, 1'b0);
            else e = eo(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
                        1'b0, 16'h0, 1'b1);
            chk($sformatf("tmo%0d", c), outs(), e);
        end
        do_reset();
        chk("tmo_err_cleared", {79'h0, err_timeout}, 80'h0);
`endif

        // Randomized run against a transaction-level model
        do_reset();
        owner  = -1;
        ptr_m  = 0;
        lat    = 1;
        cnt    = 0;
        act[0] = 0;
        act[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge Clock); #1;
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m] = 1;
                    rd[m]  = 1'($urandom_range(0, 1));
                    ad[m]  = 16'($urandom);
                    wd[m]  = 16'($urandom);
                end
            end
            drive(act[0] && rd[0], act[0] && !rd[0], ad[0], wd[0],
                  act[1] && rd[1], act[1] && !rd[1], ad[1], wd[1],
                  16'h0, 1'b0);
            if (owner >= 0) begin
                cnt++;
                s_done  = (cnt >= lat);
                s_rdata = fmem(ad[owner]);
            end else begin
                s_done  = ($urandom_range(0, 2) == 0);
                s_rdata = 16'($urandom);
            end
            @(negedge Clock);
            e = 69'h0;
            if (owner == 0)
                e = eo(rd[0], !rd[0], ad[0], wd[0], s_done, fmem(ad[0]),
                       1'b0, 16'h0, 1'b0);
            else if (owner == 1)
                e = eo(rd[1], !rd[1], ad[1], wd[1], 1'b0, 16'h0,
                       s_done, fmem(ad[1]), 1'b0);
            chk($sformatf("rnd%0d", c), outs(), e);
            if (owner >= 0) begin
                if (s_done) begin
                    act[owner] = 0;
                    ptr_m      = 1 - owner;
                    owner      = -1;
                end
            end else begin
                if (act[0] && act[1]) owner = ptr_m;
                else if (act[0]) owner = 0;
                else if (act[1]) owner = 1;
                if (owner >= 0) begin
                    lat = $urandom_range(1, 3);
                    cnt = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
